bus_invert_receiver: RTL and testbench
======================================

Name: bus_invert_receiver

Overview:
- Receive end of the bus-invert coded link: accepts encoded bus words plus the invert line over a valid/ready handshake.
- Restores original data (bus_data XOR invert) and buffers it in a small FIFO toward the consumer.
- Checks the bus-invert protocol guarantee: consecutive bus words differ in at most DATA_W/2 bits.
- Optionally keeps link activity statistics for switched-capacitance measurement.

Parameters:
- DATA_W, 8, data bus width; must be even and at least 2.
- FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_valid  in  1  encoded word present on the bus.
- bus_ready  out  1  receiver can accept a word.
- bus_data  in  DATA_W  encoded bus word.
- bus_invert  in  1  invert line; 1 means bus_data is the complement of the payload.
- out_valid  out  1  decoded word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  decoded word (FIFO head).
- err_hd  out  1  sticky protocol error flag.
- err_clr  in  1  clears err_hd.
- stat_words  out  CNT_W  count of accepted words (only with the stats feature).
- stat_toggles  out  CNT_W  count of bus line toggles (only with the stats feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empties; out_valid=0, out_data=0.
  - err_hd=0; stats counters=0.
  - prev_bus=0 and prev_inv=0; the idle bus is all-zero.
  - bus_ready=1 on the first cycle after reset release.
  - A reset mid-transfer discards all buffered words; no partial word survives.
- Accept: a word is accepted on a rising edge when bus_valid && bus_ready.
  - bus_ready = !full, registered-state only. It has no combinational dependence on out_ready, so there is no pass-through when full.
- Decode: the word pushed is bus_data XOR {DATA_W{bus_invert}}.
- Latency: a word accepted at edge N appears at the FIFO head with out_valid=1 from edge N onward (visible in cycle N+1) if the FIFO was empty.
- Output handshake: a pop occurs when out_valid && out_ready.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - Words leave in strict FIFO order.
- Simultaneous push and pop:
  - Not full: the occupancy count is unchanged and both operations happen.
  - Full: no push, since bus_ready=0.
- Occupancy limits:
  - Empty: out_valid=0; out_data holds its last value and is don't-care.
  - Full: bus_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Protocol check, on each accepted word:
  - hd = popcount(bus_data XOR prev_bus).
  - If hd > DATA_W/2, err_hd is set at that edge.
  - prev_bus and prev_inv then update to the accepted bus_data and bus_invert.
  - The word is still decoded and delivered.
  - err_clr clears err_hd at the next edge. If err_clr and a new error coincide, the error wins and err_hd stays 1.
- The state is the FIFO pointers and count only; there is no further FSM.

Optional Feature:
- Macro: BUS_INVERT_RX_STATS_EN.
- Defined:
  - stat_words increments by 1 per accepted word.
  - stat_toggles adds hd + (bus_invert != prev_inv) per accepted word.
  - Both counters saturate at all-ones and never wrap.
  - Both clear only on reset.
- Undefined: both ports are tied to 0, and no counter or popcount-for-stats logic is built. The popcount used by the protocol check remains.

Decomposition:
- Shared package bus_invert_pkg holds:
  - the DATA_W default constant;
  - the popcount function, shared with the encoder side;
  - the saturating-add function.
- One sub-module, bus_invert_fifo: a parameterized synchronous FIFO with push, pop, full, empty, asynchronous active-low reset, and head data valid while not empty.

Test Plan (DATA_W=8, FIFO_DEPTH=2):
1. Reset: hold rst_n low, then release. Expect bus_ready=1, out_valid=0, out_data=0x00, err_hd=0, stat_words=0, stat_toggles=0.
2. Decode: send bus 0x0F/inv0, then 0x0F/inv1 with out_ready=1. Expect out_data 0x0F, then 0xF0; err_hd stays 0.
3. Protocol error and clear:
   - After reset, send 0xFF/inv0 (hd 8 > 4): err_hd=1 next cycle and out_data=0xFF is still delivered.
   - Pulse err_clr: err_hd returns to 0.
   - Assert err_clr together with a new violating word: err_hd stays 1.
4. Backpressure: with out_ready=0, offer 0x01, 0x02, 0x03 (all inv0).
   - Expect two accepts, then bus_ready=0 with 0x03 held on the bus.
   - Raise out_ready: expect 0x01, 0x02, 0x03 in order, and no loss or duplication.
5. Stats (macro defined): from reset, send 0x0F/inv0, then 0x0F/inv1. Expect stat_words=2 and stat_toggles=5 (4 bus toggles plus 1 invert toggle). With the macro undefined, both read 0.
6. Reset mid-stream: fill the FIFO, then pulse rst_n low between clock edges. Expect out_valid=0 and bus_ready=1 immediately, with no stale word after release.

Source files
------------

// File: rtl/bus_invert_pkg.sv
// rtl/bus_invert_pkg.sv - shared bus-invert constants, popcount and saturating add
package bus_invert_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int MAX_W          = 64;

  function automatic logic [MAX_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + MAX_W'(v[i]);
    end
    return n;
  endfunction

  // The sum < a test catches wrap when the counter is as wide as MAX_W.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic [MAX_W-1:0] max);
    logic [MAX_W-1:0] sum;
    sum = a + b;
    if (sum < a || sum > max) begin
      return max;
    end
    return sum;
  endfunction

endpackage

// File: rtl/bus_invert_fifo.sv
// rtl/bus_invert_fifo.sv - synchronous FIFO, async active-low reset, head data valid while not empty
module bus_invert_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bus_invert_receiver.sv
// rtl/bus_invert_receiver.sv - bus-invert link receiver with decode, FIFO, protocol check; stats under BUS_INVERT_RX_STATS_EN
module bus_invert_receiver
  import bus_invert_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_invert,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_hd,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  stat_words,
  output logic [CNT_W-1:0]  stat_toggles
);

  localparam int HD_W = $clog2(DATA_W + 1);
  localparam int HALF = DATA_W / 2;

  logic              fifo_full, fifo_empty;
  logic              accept;
  logic [DATA_W-1:0] decoded;
  logic [HD_W-1:0]   hd;
  logic [DATA_W-1:0] prev_bus_q, prev_bus_d;
  logic              err_q, err_d;

  assign bus_ready = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = bus_valid && bus_ready;
  assign decoded   = bus_data ^ {DATA_W{bus_invert}};
  assign hd        = HD_W'(popcount(MAX_W'(bus_data ^ prev_bus_q)));
  assign err_hd    = err_q;

  bus_invert_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (decoded),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A new violation outranks a simultaneous clear.
  always_comb begin
    prev_bus_d = prev_bus_q;
    err_d      = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (accept) begin
      prev_bus_d = bus_data;
      if (hd > HD_W'(HALF)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bus_q <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_bus_q <= prev_bus_d;
      err_q      <= err_d;
    end
  end

`ifdef BUS_INVERT_RX_STATS_EN
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic             prev_inv_q;

  always_comb begin
    words_d   = words_q;
    toggles_d = toggles_q;
    if (accept) begin
      words_d   = CNT_W'(sat_add(MAX_W'(words_q), MAX_W'(1), MAX_W'({CNT_W{1'b1}})));
      toggles_d = CNT_W'(sat_add(MAX_W'(toggles_q),
                                 MAX_W'(hd) + MAX_W'(bus_invert != prev_inv_q),
                                 MAX_W'({CNT_W{1'b1}})));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q    <= '0;
      toggles_q  <= '0;
      prev_inv_q <= 1'b0;
    end else begin
      words_q   <= words_d;
      toggles_q <= toggles_d;
      if (accept) begin
        prev_inv_q <= bus_invert;
      end
    end
  end

  assign stat_words   = words_q;
  assign stat_toggles = toggles_q;
`else
  assign stat_words   = '0;
  assign stat_toggles = '0;
`endif

endmodule

// File: tb/tb_bus_invert_receiver.sv
// tb/tb_bus_invert_receiver.sv - directed self-checking bench for bus_invert_receiver
module tb_bus_invert_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_ready;
  logic [7:0]  bus_data;
  logic        bus_invert;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        err_hd;
  logic        err_clr;
  logic [15:0] stat_words;
  logic [15:0] stat_toggles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_invert_receiver #(
    .DATA_W     (8),
    .FIFO_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_data     (bus_data),
    .bus_invert   (bus_invert),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .err_hd       (err_hd),
    .err_clr      (err_clr),
    .stat_words   (stat_words),
    .stat_toggles (stat_toggles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus_valid  = 1'b0;
    bus_data   = 8'h00;
    bus_invert = 1'b0;
    out_ready  = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    do_reset();
    check("rst_bus_ready", 32'(bus_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_err_hd", 32'(err_hd), 32'd0);
    check("rst_stat_words", 32'(stat_words), 32'd0);
    check("rst_stat_toggles", 32'(stat_toggles), 32'd0);

    // Decode plain and inverted words, plus stats from reset
    out_ready = 1'b1;
    bus_valid = 1'b1; bus_data = 8'h0F; bus_invert = 1'b0;
    step();
    check("dec0_valid", 32'(out_valid), 32'd1);
    check("dec0_data", 32'(out_data), 32'h0F);
    check("dec0_err", 32'(err_hd), 32'd0);
    bus_invert = 1'b1;
    step();
    check("dec1_data", 32'(out_data), 32'hF0);
    check("dec1_err", 32'(err_hd), 32'd0);
`ifdef BUS_INVERT_RX_STATS_EN
    check("stat_words", 32'(stat_words), 32'd2);
    check("stat_toggles", 32'(stat_toggles), 32'd5);
`else
    check("stat_words_off", 32'(stat_words), 32'd0);
    check("stat_toggles_off", 32'(stat_toggles), 32'd0);
`endif
    bus_valid = 1'b0;
    step();
    check("dec_drained", 32'(out_valid), 32'd0);

    // Protocol error, clear, and error winning over clear
    do_reset();
    bus_valid = 1'b1; bus_data = 8'hFF; bus_invert = 1'b0;
    step();
    check("err_set", 32'(err_hd), 32'd1);
    check("err_word_delivered", 32'(out_data), 32'hFF);
    bus_valid = 1'b0;
    step();
    check("err_sticky", 32'(err_hd), 32'd1);
    err_clr = 1'b1;
    step();
    check("err_cleared", 32'(err_hd), 32'd0);
    bus_valid = 1'b1; bus_data = 8'h00;
    step();
    check("err_beats_clr", 32'(err_hd), 32'd1);
    check("err_clr_word", 32'(out_data), 32'h00);
    err_clr = 1'b0; bus_valid = 1'b0;
    step();

    // Backpressure: two accepts then hold, drain in order
    do_reset();
    out_ready = 1'b0;
    bus_valid = 1'b1; bus_data = 8'h01;
    step();
    bus_data = 8'h02;
    step();
    bus_data = 8'h03;
    check("bp_full_ready", 32'(bus_ready), 32'd0);
    step();
    check("bp_still_full", 32'(bus_ready), 32'd0);
    check("bp_head_stable", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    step();
    check("bp_pop1_ready", 32'(bus_ready), 32'd1);
    check("bp_head2", 32'(out_data), 32'h02);
    step();
    check("bp_head3", 32'(out_data), 32'h03);
    check("bp_head3_valid", 32'(out_valid), 32'd1);
    bus_valid = 1'b0;
    step();
    check("bp_no_dup", 32'(out_valid), 32'd0);
    check("bp_err_clean", 32'(err_hd), 32'd0);

    // Asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b0;
    bus_valid = 1'b1; bus_data = 8'h11;
    step();
    bus_data = 8'h13;
    step();
    bus_valid = 1'b0;
    check("mid_full", 32'(bus_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    step();
    check("mid_post_valid", 32'(out_valid), 32'd0);
    check("mid_post_data", 32'(out_data), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
